shr_harness_driver: RTL and testbench



---
 rtl/shr_harness_pkg.sv | 20 ++
 rtl/shr_serdes_shift.sv | 47 ++++
 rtl/shr_harness_driver.sv | 137 +++++++++++++
 tb/tb_shr_harness_driver.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shr_harness_pkg.sv
// Shared types and constants for the shift-register harness driver.
package shr_harness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STROBE,
        CAPTURE,
        RESULT
    } state_t;

    localparam int DIN_N_DEF  = 8;
    localparam int DOUT_N_DEF = 8;

    // Edges from vector acceptance to the edge that completes the result word.
    function automatic int latency(input int din_n, input int dout_n);
        return din_n + dout_n + 1;
    endfunction

endpackage

// File: rtl/shr_serdes_shift.sv
// Left-shifting register with parallel load; nxt_o exposes the top OUT_W bits of the next state.
module shr_serdes_shift #(
    parameter int W     = 8,
    parameter int OUT_W = W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [W-1:0]     load_data_i,
    input  logic             ser_i,
    output logic [OUT_W-1:0] nxt_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] shifted;

    generate
        if (W == 1) begin : g_narrow
            assign shifted = ser_i;
        end else begin : g_wide
            assign shifted = {q_q[W-2:0], ser_i};
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_data_i;
        end else if (shift_i) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Looking at the next state lets the owner register outputs in the same edge as the shift.
    assign nxt_o = q_d[W-1 -: OUT_W];

endmodule

// File: rtl/shr_harness_driver.sv
// Host-side initiator: serialises a stimulus vector into the shift-register harness,
// strobes it, and deserialises the returned word behind a valid/ready handshake.
module shr_harness_driver
    import shr_harness_pkg::*;
#(
    parameter int DIN_N  = DIN_N_DEF,
    parameter int DOUT_N = DOUT_N_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [DIN_N-1:0]  vec_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DOUT_N-1:0] res_data,
    output logic              di,
    output logic              stb,
    input  logic              dut_do,
    output logic              busy
);

    localparam int MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CNT_W-1:0] DIN_LAST  = CNT_W'(DIN_N - 1);
    localparam logic [CNT_W-1:0] DOUT_LAST = CNT_W'(DOUT_N - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               di_q;
    logic               stb_q;
    logic               vec_ready_q;
    logic               res_valid_q;
    logic               busy_q;
    logic [DOUT_N-1:0]  res_data_q;

    logic               accept;
    logic               stim_msb_nxt;
    logic [DOUT_N-1:0]  res_word_nxt;

    assign accept = (state_q == IDLE) && vec_valid && vec_ready_q;

    shr_serdes_shift #(
        .W     (DIN_N),
        .OUT_W (1)
    ) u_stim_piso (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .shift_i     (state_q == SHIFT),
        .load_data_i (vec_data),
        .ser_i       (1'b0),
        .nxt_o       (stim_msb_nxt)
    );

    shr_serdes_shift #(
        .W     (DOUT_N),
        .OUT_W (DOUT_N)
    ) u_res_sipo (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (1'b0),
        .shift_i     (state_q == CAPTURE),
        .load_data_i ('0),
        .ser_i       (dut_do),
        .nxt_o       (res_word_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            di_q        <= 1'b0;
            stb_q       <= 1'b0;
            vec_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= SHIFT;
                        cnt_q       <= DIN_LAST;
                        di_q        <= stim_msb_nxt;
                        vec_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        state_q <= STROBE;
                        di_q    <= 1'b0;
                        stb_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        di_q  <= stim_msb_nxt;
                    end
                end
                STROBE: begin
                    state_q <= CAPTURE;
                    stb_q   <= 1'b0;
                    cnt_q   <= DOUT_LAST;
                end
                CAPTURE: begin
                    // The last sample is folded in through the SIPO's next-state view.
                    if (cnt_q == '0) begin
                        state_q     <= RESULT;
                        res_data_q  <= res_word_nxt;
                        res_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        vec_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_ready = vec_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign di        = di_q;
    assign stb       = stb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shr_harness_driver.sv
// Bench for shr_harness_driver: 8/8 and 1/1 instances, each wired to a behavioural
// harness whose dout is its previously latched din.
module tb_shr_harness_driver;
    import shr_harness_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // 8/8 instance signals
    logic       vec_valid8 = 1'b0, vec_ready8, res_valid8, res_ready8 = 1'b0;
    logic [7:0] vec_data8 = 8'h00, res_data8;
    logic       di8, stb8, do8, busy8;

    // 1/1 instance signals
    logic       vec_valid1 = 1'b0, vec_ready1, res_valid1, res_ready1 = 1'b0;
    logic [0:0] vec_data1 = 1'b0, res_data1;
    logic       di1, stb1, do1, busy1;

    shr_harness_driver #(.DIN_N(8), .DOUT_N(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vec_valid8), .vec_ready(vec_ready8), .vec_data(vec_data8),
        .res_valid(res_valid8), .res_ready(res_ready8), .res_data(res_data8),
        .di(di8), .stb(stb8), .dut_do(do8), .busy(busy8)
    );

    shr_harness_driver #(.DIN_N(1), .DOUT_N(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vec_valid1), .vec_ready(vec_ready1), .vec_data(vec_data1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1),
        .di(di1), .stb(stb1), .dut_do(do1), .busy(busy1)
    );

    // Behavioural harnesses (not reset by rst_n; their contents survive a driver reset)
    logic [7:0] din_shr8 = 8'h00, din8 = 8'h00, dout_shr8 = 8'h00;
    always @(posedge clk) begin
        din_shr8 <= {din_shr8[6:0], di8};
        if (stb8) begin
            din8      <= din_shr8;
            dout_shr8 <= din8;
        end else begin
            dout_shr8 <= {dout_shr8[6:0], 1'b0};
        end
    end
    assign do8 = dout_shr8[7];

    logic din_shr1 = 1'b0, din1 = 1'b0, dout_shr1 = 1'b0;
    always @(posedge clk) begin
        din_shr1 <= di1;
        if (stb1) begin
            din1      <= din_shr1;
            dout_shr1 <= din1;
        end else begin
            dout_shr1 <= 1'b0;
        end
    end
    assign do1 = dout_shr1;

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endfunction

    function automatic void chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Protocol invariants, sampled mid-cycle
    logic prev_stb8 = 1'b0, prev_stb1 = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk1("stb8_back_to_back", stb8 & prev_stb8, 1'b0);
            chk1("stb1_back_to_back", stb1 & prev_stb1, 1'b0);
            chk1("di8_outside_shift", (dut8.state_q != SHIFT) & di8, 1'b0);
            chk1("di1_outside_shift", (dut1.state_q != SHIFT) & di1, 1'b0);
            chk1("stb8_outside_strobe", (dut8.state_q != STROBE) & stb8, 1'b0);
        end
        prev_stb8 = stb8;
        prev_stb1 = stb1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn8(input logic [7:0] v, input logic rr, output logic [7:0] r,
                        output int lat, output int acc);
        int   n;
        logic saw_ready;
        n = 0;
        while (!vec_ready8 && n < 40) begin
            tick();
            n++;
        end
        chk1("vec_ready8_wait", vec_ready8, 1'b1);
        res_ready8 = rr;
        vec_valid8 = 1'b1;
        vec_data8  = v;
        tick();
        acc        = cyc;
        vec_valid8 = 1'b0;
        vec_data8  = ~v;
        n          = 0;
        saw_ready  = 1'b0;
        while (!res_valid8 && n < 40) begin
            saw_ready = saw_ready | vec_ready8;
            tick();
            n++;
        end
        chk1("vec_ready8_low_in_txn", saw_ready | vec_ready8, 1'b0);
        chk1("res_valid8_seen", res_valid8, 1'b1);
        lat = n;
        r   = res_data8;
        if (rr) begin
            tick();
            chk1("res_valid8_drop", res_valid8, 1'b0);
        end
    endtask

    task automatic txn1(input logic v, output logic r, output int lat);
        int n;
        res_ready1   = 1'b1;
        vec_valid1   = 1'b1;
        vec_data1[0] = v;
        tick();
        vec_valid1   = 1'b0;
        vec_data1[0] = ~v;
        n = 0;
        while (!res_valid1 && n < 20) begin
            tick();
            n++;
        end
        chk1("res_valid1_seen", res_valid1, 1'b1);
        lat = n;
        r   = res_data1[0];
        tick();
        chk1("vec_ready1_back", vec_ready1, 1'b1);
    endtask

    typedef struct {
        logic [7:0] vec;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [4];
    logic [7:0] latched8;
    logic       latched1;
    logic [7:0] v8, r8, exp_hold;
    logic       r1;
    int         lat, acc, prev_acc;

    initial begin
        tbl[0] = '{vec: 8'h3C, exp: 8'hA5};
        tbl[1] = '{vec: 8'hFF, exp: 8'h3C};
        tbl[2] = '{vec: 8'h00, exp: 8'hFF};
        tbl[3] = '{vec: 8'h5A, exp: 8'h00};
        latched8 = 8'h00;
        latched1 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_vec_ready", vec_ready8, 1'b1);
        chk1("rst_busy", busy8, 1'b0);
        chk1("rst_res_valid", res_valid8, 1'b0);
        chk8("rst_res_data", res_data8, 8'h00);
        chk1("rst_di", di8, 1'b0);
        chk1("rst_stb", stb8, 1'b0);
        chk1("rst1_vec_ready", vec_ready1, 1'b1);
        rst_n = 1'b1;
        tick();

        // 8'hA5, edge by edge
        v8 = 8'hA5;
        chk1("a5_idle_ready", vec_ready8, 1'b1);
        vec_valid8 = 1'b1;
        vec_data8  = v8;
        tick();
        vec_valid8 = 1'b0;
        vec_data8  = 8'h00;
        chk1("a5_busy", busy8, 1'b1);
        chk1("a5_vec_ready_low", vec_ready8, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            chk1($sformatf("a5_di_E%0d", k), di8, v8[8-k]);
            chk1("a5_stb_low_in_shift", stb8, 1'b0);
            tick();
        end
        chk1("a5_stb_before_E9", stb8, 1'b1);
        chk1("a5_di_in_strobe", di8, 1'b0);
        tick();
        chk1("a5_stb_after_E9", stb8, 1'b0);
        repeat (7) begin
            chk1("a5_res_valid_early", res_valid8, 1'b0);
            tick();
        end
        chk1("a5_res_valid_E16", res_valid8, 1'b0);
        tick();
        chk1("a5_res_valid_E17", res_valid8, 1'b1);
        chk8("a5_res_data", res_data8, latched8);
        latched8   = v8;
        res_ready8 = 1'b1;
        tick();
        chk1("a5_res_valid_drop", res_valid8, 1'b0);
        chk1("a5_vec_ready_back", vec_ready8, 1'b1);
        chk1("a5_busy_drop", busy8, 1'b0);

        // Back-to-back table, res_ready tied high
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            txn8(tbl[i].vec, 1'b1, r8, lat, acc);
            chk8($sformatf("tbl%0d_res", i), r8, tbl[i].exp);
            chki("tbl_latency", lat, latency(8, 8));
            if (i > 0) chki("tbl_throughput", acc - prev_acc, 8 + 8 + 3);
            prev_acc = acc;
        end
        latched8 = tbl[3].vec;

        // Randomised transactions against the "previous vector" model
        for (int i = 0; i < 12; i++) begin
            v8 = 8'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            txn8(v8, 1'b1, r8, lat, acc);
            chk8($sformatf("rand%0d_res", i), r8, latched8);
            chki("rand_latency", lat, latency(8, 8));
            latched8 = v8;
        end

        // res_ready held low in RESULT with a competing vector offered
        v8 = 8'h96;
        exp_hold = latched8;
        txn8(v8, 1'b0, r8, lat, acc);
        chk8("hold_res", r8, exp_hold);
        latched8 = v8;
        for (int i = 0; i < 5; i++) begin
            vec_valid8 = 1'b1;
            vec_data8  = 8'h77;
            tick();
            chk1("hold_res_valid", res_valid8, 1'b1);
            chk1("hold_vec_ready", vec_ready8, 1'b0);
            chk8("hold_res_data", res_data8, exp_hold);
        end
        res_ready8 = 1'b1;
        tick();
        vec_valid8 = 1'b0;
        chk1("hold_no_accept_on_handshake", busy8, 1'b0);
        chk1("hold_vec_ready_after", vec_ready8, 1'b1);
        chk1("hold_res_valid_after", res_valid8, 1'b0);
        v8 = 8'($urandom);
        txn8(v8, 1'b1, r8, lat, acc);
        chk8("after_hold_res", r8, latched8);
        latched8 = v8;

        // Asynchronous reset during SHIFT bit 4
        vec_valid8 = 1'b1;
        vec_data8  = 8'hC3;
        tick();
        vec_valid8 = 1'b0;
        repeat (4) tick();
        chk1("pre_reset_busy", busy8, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk1("arst_vec_ready", vec_ready8, 1'b1);
        chk1("arst_busy", busy8, 1'b0);
        chk1("arst_di", di8, 1'b0);
        chk1("arst_stb", stb8, 1'b0);
        chk1("arst_res_valid", res_valid8, 1'b0);
        chk8("arst_res_data", res_data8, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        txn8(8'h81, 1'b1, r8, lat, acc);
        chk8("post_reset_res", r8, latched8);
        latched8 = 8'h81;
        v8 = 8'($urandom);
        txn8(v8, 1'b1, r8, lat, acc);
        chk8("post_reset_81_back", r8, 8'h81);
        latched8 = v8;

        // 1/1 build
        txn1(1'b1, r1, lat);
        chk1("n1_first", r1, latched1);
        chki("n1_latency", lat, latency(1, 1));
        latched1 = 1'b1;
        txn1(1'b1, r1, lat);
        chk1("n1_second", r1, 1'b1);
        chki("n1_latency2", lat, latency(1, 1));
        txn1(1'b0, r1, lat);
        chk1("n1_third", r1, 1'b1);
        txn1(1'b1, r1, lat);
        chk1("n1_fourth", r1, 1'b0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
